// File: rtl/radio_pkg.sv
// Shared radio constants, state typedef and fixed-point helpers.
package radio_pkg;

  localparam int unsigned DATA_SIZE = 32;
  localparam int unsigned BITS      = 10;
  localparam int unsigned PROD_W    = 2 * DATA_SIZE;

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_MULT  = 2'd1,
    S_WRITE = 2'd2
  } lmr_state_e;

  // Signed divide by 2^i_bits rounding toward zero, wrapped to DATA_SIZE bits.
  // Negative values get (2^i_bits - 1) added so the arithmetic shift truncates
  // toward zero instead of toward minus infinity.
  function automatic logic [DATA_SIZE-1:0] dequantize(
    input logic signed [PROD_W-1:0] i_prod,
    input int unsigned              i_bits
  );
    logic signed [PROD_W-1:0] w_bias;
    logic signed [PROD_W-1:0] w_biased;
    w_bias   = $signed((PROD_W'(1) << i_bits) - PROD_W'(1));
    w_biased = i_prod[PROD_W-1] ? (i_prod + w_bias) : i_prod;
    return DATA_SIZE'(w_biased >>> i_bits);
  endfunction

endpackage

// File: rtl/stereo_lmr_mixer_if.sv
// FIFO-side signals of the L-R mixer: two show-ahead inputs and one output FIFO.
interface stereo_lmr_mixer_if
  import radio_pkg::*;
#(
  parameter int unsigned DATA_SIZE = radio_pkg::DATA_SIZE
) ();

  logic [DATA_SIZE-1:0] carrier_dout;
  logic                 carrier_empty;
  logic                 carrier_rd_en;
  logic [DATA_SIZE-1:0] lmr_dout;
  logic                 lmr_empty;
  logic                 lmr_rd_en;
  logic [DATA_SIZE-1:0] mix_out;
  logic                 mix_wr_en;
  logic                 mix_full;

  // Mixer side
  modport master (
    input  carrier_dout, carrier_empty, lmr_dout, lmr_empty, mix_full,
    output carrier_rd_en, lmr_rd_en, mix_out, mix_wr_en
  );

  // FIFO / environment side
  modport slave (
    output carrier_dout, carrier_empty, lmr_dout, lmr_empty, mix_full,
    input  carrier_rd_en, lmr_rd_en, mix_out, mix_wr_en
  );

endinterface

// File: rtl/stereo_lmr_mixer.sv
// Stereo L-R demodulating mixer: joins carrier and L-R samples, multiplies,
// dequantizes and writes the baseband sample downstream.
module stereo_lmr_mixer
  import radio_pkg::*;
#(
  parameter int unsigned DATA_SIZE = radio_pkg::DATA_SIZE,
  parameter int unsigned BITS      = radio_pkg::BITS
) (
  input logic                clock,
  input logic                reset,
  stereo_lmr_mixer_if.master bus
);

  localparam int unsigned PW = 2 * DATA_SIZE;

  lmr_state_e                  r_state;
  lmr_state_e                  w_state_nxt;
  logic signed [DATA_SIZE-1:0] r_carrier;
  logic signed [DATA_SIZE-1:0] r_lmr;
  logic signed [PW-1:0]        r_product;
  logic signed [PW-1:0]        w_product;
  logic                        w_both_ready;
  logic                        w_pop;
  logic                        w_write;

  assign w_both_ready = !bus.carrier_empty && !bus.lmr_empty;
  assign w_product    = PW'(r_carrier) * PW'(r_lmr);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_READ;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: strict join on read, hold on full output FIFO
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_READ:  if (w_both_ready) w_state_nxt = S_MULT;
      S_MULT:  w_state_nxt = S_WRITE;
      S_WRITE: if (!bus.mix_full) w_state_nxt = S_WRITE == r_state ? S_READ : r_state;
      default: w_state_nxt = S_READ;
    endcase
  end

  // Output strobes; both FIFOs always pop together, nothing moves in reset
  always_comb begin
    w_pop   = 1'b0;
    w_write = 1'b0;
    if (!reset) begin
      case (r_state)
        S_READ:  w_pop   = w_both_ready;
        S_WRITE: w_write = !bus.mix_full;
        default: ;
      endcase
    end
  end

  // Operand capture on the joint pop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_carrier <= '0;
      r_lmr     <= '0;
    end else if (w_pop) begin
      r_carrier <= $signed(bus.carrier_dout);
      r_lmr     <= $signed(bus.lmr_dout);
    end
  end

  // Full-width product, updated only in S_MULT so mix_out holds through S_WRITE
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 r_product <= '0;
    else if (r_state == S_MULT) r_product <= w_product;
  end

  assign bus.carrier_rd_en = w_pop;
  assign bus.lmr_rd_en     = w_pop;
  assign bus.mix_wr_en     = w_write;
  assign bus.mix_out       = dequantize(r_product, BITS);

endmodule

// File: tb/tb_stereo_lmr_mixer.sv
// Directed and randomized checks of the L-R mixer against show-ahead FIFO models.
module tb_stereo_lmr_mixer;
  import radio_pkg::*;

  localparam int unsigned N_RAND = 1000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  stereo_lmr_mixer_if #(.DATA_SIZE(DATA_SIZE)) bus ();

  stereo_lmr_mixer #(.DATA_SIZE(DATA_SIZE), .BITS(BITS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [31:0] cq[$];
  logic [31:0] lq[$];
  logic [31:0] got_q[$];
  logic [31:0] rc[N_RAND];
  logic [31:0] rl[N_RAND];
  logic        full_q;
  logic        s_crd, s_lrd, s_wr;
  logic [31:0] s_mix;
  logic [31:0] junk;
  int          cyc, last_pop, last_wr, pops_c, pops_l, join_err;
  int          n_chk, n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                  tag, $signed(got), got, $signed(exp), exp);
  endtask

  // Reference: exact 64-bit product, SV integer division truncates toward zero
  function automatic logic [31:0] golden(input logic [31:0] c, input logic [31:0] l);
    longint p;
    p = longint'($signed(c)) * longint'($signed(l));
    p = p / (longint'(1) << BITS);
    return p[31:0];
  endfunction

  task automatic drive();
    bus.carrier_empty = (cq.size() == 0);
    bus.lmr_empty     = (lq.size() == 0);
    bus.carrier_dout  = (cq.size() != 0) ? cq[0] : 32'd0;
    bus.lmr_dout      = (lq.size() != 0) ? lq[0] : 32'd0;
    bus.mix_full      = full_q;
  endtask

  task automatic push(input logic [31:0] c, input logic [31:0] l);
    cq.push_back(c);
    lq.push_back(l);
    drive();
    #1;
  endtask

  // Sample the current cycle mid-period, then advance one clock and apply pops
  task automatic step();
    s_crd = bus.carrier_rd_en;
    s_lrd = bus.lmr_rd_en;
    s_wr  = bus.mix_wr_en;
    s_mix = bus.mix_out;
    if (s_crd !== s_lrd) join_err++;
    if (s_crd) begin pops_c++; last_pop = cyc; end
    if (s_lrd) pops_l++;
    if (s_wr) begin got_q.push_back(s_mix); last_wr = cyc; end
    @(posedge clock);
    #1;
    if (s_crd && cq.size() != 0) junk = cq.pop_front();
    if (s_lrd && lq.size() != 0) junk = lq.pop_front();
    cyc++;
    drive();
    #1;
  endtask

  task automatic run_until_write(input string tag, input int max_cyc);
    int n0;
    int k;
    n0 = got_q.size();
    k  = 0;
    while (got_q.size() == n0 && k < max_cyc) begin
      step();
      k++;
    end
    if (got_q.size() == n0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int stray, viol, n0, nc, nl, guard, tmp;
    n_chk = 0; n_pass = 0; cyc = 0; last_pop = 0; last_wr = 0;
    pops_c = 0; pops_l = 0; join_err = 0;
    reset  = 1'b1;
    full_q = 1'b0;
    drive();
    repeat (2) @(posedge clock);
    #2;

    // Reset state, with data waiting to prove nothing pops during reset
    check("rst_mix_out", bus.mix_out, 32'd0);
    check("rst_wr_en", 32'(bus.mix_wr_en), 32'd0);
    push(32'd1024, 32'd512);
    check("rst_rd_en", {30'd0, bus.carrier_rd_en, bus.lmr_rd_en}, 32'd0);
    step();
    reset = 1'b0;
    #1;

    // Basic product and latency; both flags non-empty in the same cycle
    step();
    check("t1_pop_both", {30'd0, s_crd, s_lrd}, 32'd3);
    run_until_write("t1", 10);
    check("t1_val", got_q[$], 32'd512);
    check("t1_latency", 32'(last_wr - last_pop), 32'd2);

    // Sign handling and round toward zero
    push(-32'sd1024, 32'd3);
    run_until_write("t2a", 10);
    check("t2a_val", got_q[$], 32'(-3));
    push(32'd5, -32'sd100);
    run_until_write("t2b", 10);
    check("t2b_round_zero", got_q[$], 32'd0);

    // Only L-R available: no pops until carrier arrives
    lq.push_back(32'd77);
    drive();
    #1;
    stray = 0;
    repeat (20) begin
      step();
      if (s_crd || s_lrd) stray++;
    end
    check("t3_no_pop", 32'(stray), 32'd0);
    cq.push_back(-32'sd4096);
    drive();
    #1;
    step();
    check("t3_join_pop", {30'd0, s_crd, s_lrd}, 32'd3);
    run_until_write("t3", 10);
    check("t3_val", got_q[$], 32'(-308));
    check("t3_pop_counts", 32'(pops_c), 32'(pops_l));

    // Backpressure for 10 cycles in S_WRITE
    full_q = 1'b1;
    push(32'd3000, -32'sd7);
    push(32'd100, 32'd100);
    step();
    check("t4_pop", 32'(s_crd), 32'd1);
    step();
    viol = 0;
    repeat (10) begin
      step();
      if (s_wr || s_crd || s_lrd) viol++;
      if (s_mix !== 32'(-20)) viol++;
    end
    check("t4_hold", 32'(viol), 32'd0);
    full_q = 1'b0;
    drive();
    #1;
    step();
    check("t4_write", 32'(s_wr), 32'd1);
    check("t4_no_pop_on_write", 32'(s_crd), 32'd0);
    check("t4_val", s_mix, 32'(-20));
    step();
    check("t4_next_pop", 32'(s_crd), 32'd1);
    run_until_write("t4b", 10);
    check("t4b_val", got_q[$], 32'd9);

    // Reset while in S_MULT discards the in-flight sample
    push(32'd11, 32'd13);
    step();
    check("t5_pop", 32'(s_crd), 32'd1);
    reset = 1'b1;
    #1;
    check("t5_rst_mix_out", bus.mix_out, 32'd0);
    check("t5_rst_strobes",
          {29'd0, bus.mix_wr_en, bus.carrier_rd_en, bus.lmr_rd_en}, 32'd0);
    n0 = got_q.size();
    repeat (3) step();
    reset = 1'b0;
    #1;
    repeat (3) step();
    check("t5_no_write", 32'(got_q.size()), 32'(n0));
    push(32'd2048, 32'd2048);
    run_until_write("t5", 10);
    check("t5_val", got_q[$], 32'd4096);

    // Random stream with independent arrival gaps and random backpressure
    for (int i = 0; i < int'(N_RAND); i++) begin
      if ($urandom_range(0, 1) == 0) begin
        rc[i] = $urandom();
        rl[i] = $urandom();
      end else begin
        tmp = int'($urandom_range(0, 4000)) - 2000;
        rc[i] = tmp;
        tmp = int'($urandom_range(0, 4000)) - 2000;
        rl[i] = tmp;
      end
    end
    got_q.delete();
    nc = 0; nl = 0; guard = 0;
    while (got_q.size() < int'(N_RAND) && guard < 40000) begin
      if (nc < int'(N_RAND) && $urandom_range(0, 3) == 0) begin cq.push_back(rc[nc]); nc++; end
      if (nl < int'(N_RAND) && $urandom_range(0, 3) == 0) begin lq.push_back(rl[nl]); nl++; end
      full_q = ($urandom_range(0, 3) == 0);
      drive();
      #1;
      step();
      guard++;
    end
    check("t6_count", 32'(got_q.size()), 32'(N_RAND));
    for (int i = 0; i < got_q.size() && i < int'(N_RAND); i++)
      check($sformatf("t6_sample%0d", i), got_q[i], golden(rc[i], rl[i]));
    check("t6_join_err", 32'(join_err), 32'd0);
    check("t6_pop_counts", 32'(pops_c), 32'(pops_l));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
